// File: rtl/vga_key_overlay.sv
// vga_key_overlay: VGA timing generator that blends per-key colour stripes
// over a background image streamed from an external ROM. Each key has an
// 8-bit intensity that jumps to full on press and fades once per frame
// after release.
//
// Ports:
//   iVGA_CLK          pixel clock (single clock domain)
//   iRST              asynchronous active-high reset
//   iKEYS             key-held flags, asynchronous, bit k = key k
//   iBGR              background pixel {b,g,r}, valid 1 cycle after oADDR
//   oADDR             background ROM address, linear y*H_ACTIVE+x
//   oHS, oVS          active-low syncs, aligned with the colour outputs
//   oBLANK_n          high on active-video pixels, aligned with colour
//   b_data/g_data/r_data  registered pixel colour
module vga_key_overlay #(
  parameter int unsigned NUM_KEYS  = 7,
  parameter int unsigned KEY_W     = 91,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic [7:0]  FADE_STEP = 8'h20
) (
  input  logic                iVGA_CLK,
  input  logic                iRST,
  input  logic [NUM_KEYS-1:0] iKEYS,
  input  logic [23:0]         iBGR,
  output logic [18:0]         oADDR,
  output logic                oHS,
  output logic                oVS,
  output logic                oBLANK_n,
  output logic [7:0]          b_data,
  output logic [7:0]          g_data,
  output logic [7:0]          r_data
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned CW       = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int unsigned KW       = $clog2(NUM_KEYS + 1);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Stage 0: raster counters, ROM address and key column tracking
  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [18:0]         addr_q, addr_d;
  logic [CW-1:0]       col_q, col_d;
  logic [KW-1:0]       kidx_q, kidx_d;
  logic [NUM_KEYS-1:0] keys_meta_q, keys_sync_q;
  logic [7:0]          lvl_q [NUM_KEYS];
  logic [7:0]          lvl_d [NUM_KEYS];

  // Stage 1: pixel attributes waiting for the ROM data
  logic          s1_act_q, s1_hs_q, s1_vs_q, s1_key_q;
  logic [KW-1:0] s1_kidx_q;
  logic [7:0]    s1_lvl_q;

  // Stage 2: registered outputs
  logic       hs_q, vs_q, blank_q;
  logic [7:0] b_q, g_q, r_q;
  logic [7:0] b_d, g_d, r_d;

  logic       h_end_c, v_end_c, act_c, hs_raw_c, vs_raw_c, upd_c, is_key_c;
  logic [7:0] sel_lvl_c;
  logic [9:0] kc10_c;
  logic [7:0] kc_b_c, kc_r_c;

  // (kc*L + bg*(255-L)) >> 8 evaluated at 16 bits; the sum never exceeds 65025
  function automatic logic [7:0] blend(input logic [7:0] kc, input logic [7:0] bg,
                                       input logic [7:0] lvl);
    logic [15:0] acc;
    acc = 16'(kc) * 16'(lvl) + 16'(bg) * 16'(8'hFF - lvl);
    return acc[15:8];
  endfunction

  // Raster counters, address and incremental key index
  always_comb begin
    h_end_c  = (h_q == HW'(H_TOTAL - 1));
    v_end_c  = (v_q == VW'(V_TOTAL - 1));
    act_c    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_raw_c = !((32'(h_q) >= HS_START) && (32'(h_q) < HS_END));
    vs_raw_c = !((32'(v_q) >= VS_START) && (32'(v_q) < VS_END));
    upd_c    = (h_q == '0) && (32'(v_q) == V_ACTIVE);
    is_key_c = (32'(kidx_q) < NUM_KEYS);

    h_d    = h_end_c ? '0 : h_q + HW'(1);
    v_d    = v_q;
    addr_d = addr_q;
    col_d  = col_q;
    kidx_d = kidx_q;
    if (h_end_c) begin
      v_d = v_end_c ? '0 : v_q + VW'(1);
    end
    if (h_end_c && v_end_c) begin
      addr_d = '0;
    end else if (act_c) begin
      addr_d = addr_q + 19'd1;
    end
    // Column counter restarts each line; the index saturates at NUM_KEYS (non-key)
    if (h_end_c) begin
      col_d  = '0;
      kidx_d = '0;
    end else if (col_q == CW'(KEY_W - 1)) begin
      col_d = '0;
      if (32'(kidx_q) < NUM_KEYS) begin
        kidx_d = kidx_q + KW'(1);
      end
    end else begin
      col_d = col_q + CW'(1);
    end
  end

  // Per-key levels change only on the frame-update pulse, outside active video
  always_comb begin
    sel_lvl_c = 8'h00;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      lvl_d[k] = lvl_q[k];
      if (upd_c) begin
        if (keys_sync_q[k]) begin
          lvl_d[k] = 8'hFF;
        end else if (lvl_q[k] > FADE_STEP) begin
          lvl_d[k] = lvl_q[k] - FADE_STEP;
        end else begin
          lvl_d[k] = 8'h00;
        end
      end
      if (kidx_q == KW'(k)) begin
        sel_lvl_c = lvl_q[k];
      end
    end
  end

  // Key colour ramps red->blue with index; blended only when the level is nonzero
  always_comb begin
    kc10_c = 10'(s1_kidx_q) << 5;
    kc_b_c = (kc10_c > 10'd255) ? 8'hFF : kc10_c[7:0];
    kc_r_c = 8'hFF - kc_b_c;
    b_d    = 8'h00;
    g_d    = 8'h00;
    r_d    = 8'h00;
    if (s1_act_q) begin
      b_d = iBGR[23:16];
      g_d = iBGR[15:8];
      r_d = iBGR[7:0];
      if (s1_key_q && (s1_lvl_q != 8'h00)) begin
        b_d = blend(kc_b_c, iBGR[23:16], s1_lvl_q);
        g_d = blend(8'h00,  iBGR[15:8],  s1_lvl_q);
        r_d = blend(kc_r_c, iBGR[7:0],   s1_lvl_q);
      end
    end
  end

  // All state
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      h_q         <= '0;
      v_q         <= '0;
      addr_q      <= '0;
      col_q       <= '0;
      kidx_q      <= '0;
      keys_meta_q <= '0;
      keys_sync_q <= '0;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        lvl_q[k] <= 8'h00;
      end
      s1_act_q    <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      s1_key_q    <= 1'b0;
      s1_kidx_q   <= '0;
      s1_lvl_q    <= 8'h00;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      b_q         <= 8'h00;
      g_q         <= 8'h00;
      r_q         <= 8'h00;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      kidx_q      <= kidx_d;
      keys_meta_q <= iKEYS;
      keys_sync_q <= keys_meta_q;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        lvl_q[k] <= lvl_d[k];
      end
      s1_act_q    <= act_c;
      s1_hs_q     <= hs_raw_c;
      s1_vs_q     <= vs_raw_c;
      s1_key_q    <= is_key_c;
      s1_kidx_q   <= kidx_q;
      s1_lvl_q    <= sel_lvl_c;
      hs_q        <= s1_hs_q;
      vs_q        <= s1_vs_q;
      blank_q     <= s1_act_q;
      b_q         <= b_d;
      g_q         <= g_d;
      r_q         <= r_d;
    end
  end

  assign oADDR    = addr_q;
  assign oHS      = hs_q;
  assign oVS      = vs_q;
  assign oBLANK_n = blank_q;
  assign b_data   = b_q;
  assign g_data   = g_q;
  assign r_data   = r_q;

endmodule

// File: tb/tb_vga_key_overlay.sv
// Testbench for vga_key_overlay on a reduced raster (56x17 total, 40x10
// active, 3 keys of 8 pixels). The bench acts as the background ROM and
// keeps an independent raster/level model; expected pixels are queued as
// each raster position is driven and compared when they emerge 2 cycles later.
module tb_vga_key_overlay;

  localparam int NK = 3;
  localparam int KW = 8;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] keys;
  logic [23:0]   bgr;
  logic [18:0]   addr;
  logic          hs, vs, blank_n;
  logic [7:0]    b, g, r;

  vga_key_overlay #(
    .NUM_KEYS(NK), .KEY_W(KW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FADE_STEP(8'h20)
  ) dut (
    .iVGA_CLK(clk), .iRST(rst), .iKEYS(keys), .iBGR(bgr),
    .oADDR(addr), .oHS(hs), .oVS(vs), .oBLANK_n(blank_n),
    .b_data(b), .g_data(g), .r_data(r)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          mh, mv, frame;
  logic [7:0]  ml [NK];
  logic [NK-1:0] kh1, kh2;
  logic [18:0] prev_addr;
  logic [26:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Background image contents
  function automatic logic [23:0] rom(input logic [18:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo ^ 8'hA5, a[8:1] + 8'h3C, (lo * 8'd7) ^ 8'h5A};
  endfunction

  function automatic logic [18:0] model_addr(input int h, input int v);
    if (v < VA) return 19'(v * HA + ((h < HA) ? h : HA));
    return 19'(HA * VA);
  endfunction

  // Expected {hs,vs,blank_n,b,g,r} for raster position (h,v) with current levels
  function automatic logic [26:0] expect_pix(input int h, input int v);
    logic [23:0] bg;
    logic        phs, pvs;
    int          idx, lv, kb, kr, ob, og, orr;
    phs = !(h >= HA + HF && h < HA + HF + HS);
    pvs = !(v >= VA + VF && v < VA + VF + VS);
    if (!(h < HA && v < VA)) return {phs, pvs, 1'b0, 24'h000000};
    bg  = rom(model_addr(h, v));
    ob  = int'(bg[23:16]);
    og  = int'(bg[15:8]);
    orr = int'(bg[7:0]);
    idx = h / KW;
    if (idx < NK && ml[idx] != 8'h00) begin
      lv  = int'(ml[idx]);
      kb  = (idx * 32 > 255) ? 255 : idx * 32;
      kr  = 255 - kb;
      ob  = (kb * lv + ob * (255 - lv)) / 256;
      og  = (og * (255 - lv)) / 256;
      orr = (kr * lv + orr * (255 - lv)) / 256;
    end
    return {phs, pvs, 1'b1, 8'(ob), 8'(og), 8'(orr)};
  endfunction

  // One pixel period, entered at a falling edge
  task automatic step(input logic [NK-1:0] k);
    logic [26:0]   got, e;
    logic [NK-1:0] use_k;
    got = {hs, vs, blank_n, b, g, r};
    check($sformatf("addr f%0d v%0d h%0d", frame, mv, mh), 32'(addr), 32'(model_addr(mh, mv)));
    bgr       = rom(prev_addr);
    prev_addr = addr;
    keys      = k;
    use_k     = kh2;
    kh2       = kh1;
    kh1       = k;
    exp_q.push_back(expect_pix(mh, mv));
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check($sformatf("pix f%0d v%0d h%0d", frame, mv, mh), 32'(got), 32'(e));
    end
    if (mh == 0 && mv == VA) begin
      for (int i = 0; i < NK; i++) begin
        if (use_k[i]) ml[i] = 8'hFF;
        else if (ml[i] > 8'h20) ml[i] = ml[i] - 8'h20;
        else ml[i] = 8'h00;
      end
    end
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) begin
        mv = 0;
        frame++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int f, input int v, input logic [NK-1:0] k);
    while (frame < f || (frame == f && mv < v)) step(k);
  endtask

  // Drop reset at a falling edge and restart the model from the origin
  task automatic release_reset();
    rst       = 1'b0;
    mh        = 0;
    mv        = 0;
    frame     = 0;
    kh1       = '0;
    kh2       = '0;
    prev_addr = '0;
    for (int i = 0; i < NK; i++) ml[i] = 8'h00;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b1, 1'b0, 24'h000000});
    exp_q.push_back({1'b1, 1'b1, 1'b0, 24'h000000});
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    bgr  = '0;
    repeat (2) @(negedge clk);
    check("reset addr", 32'(addr), 32'd0);
    check("reset syncs", 32'({hs, vs, blank_n}), 32'(3'b110));
    release_reset();

    run_to(1, 5, 3'b000);   // plain background
    run_to(2, 5, 3'b101);   // press mid-frame: visible from frame 2
    run_to(3, 3, 3'b010);   // release 0,2 mid-frame 2, press key 1
    run_to(12, 3, 3'b000);  // fade to zero and hold
    run_to(13, 4, 3'b111);  // all keys at full, stripes 3/4 pass through
    while (mh < 20) step(3'b111);

    // Asynchronous reset mid-line with keys held
    #1 rst = 1'b1;
    #1;
    check("async rst addr", 32'(addr), 32'd0);
    check("async rst syncs", 32'({hs, vs, blank_n}), 32'(3'b110));
    check("async rst colour", 32'({b, g, r}), 32'd0);
    repeat (3) @(negedge clk);
    release_reset();
    run_to(2, 2, 3'b111);   // frame 0 must show background only

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_key_overlay.md
VGA_KEY_OVERLAY -- requirements
Module: vga_key_overlay

Interface
REQ-001 Parameter NUM_KEYS, default 7: number of key stripes (1..16).
REQ-002 Parameter KEY_W, default 91: key stripe width in pixels along x.
REQ-003 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels.
REQ-004 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-005 Parameter FADE_STEP, default 8'h20: per-frame intensity decrement after key release.
REQ-006 iVGA_CLK  in  1  pixel clock; the block has one clock.
REQ-007 iRST  in  1  reset, asynchronous, active-high.
REQ-008 iKEYS  in  NUM_KEYS  key-held flags, asynchronous to iVGA_CLK; bit k = key k.
REQ-009 iBGR  in  24  background pixel {b,g,r} from the image ROM, valid exactly 1 cycle after oADDR.
REQ-010 oADDR  out  19  background ROM address, linear y*H_ACTIVE+x.
REQ-011 oHS, oVS  out  1 each  sync outputs, active-low.
REQ-012 oBLANK_n  out  1  high on active-video pixels.
REQ-013 b_data, g_data, r_data  out  8 each  pixel colour channels.

Function
REQ-014 The block SHALL keep h counting 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters) and v counting 0..V_TOTAL-1; v increments when h wraps; both wrap to 0 together at frame end.
REQ-015 Raw sync SHALL be low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and for v in the corresponding V range; raw active SHALL be (h<H_ACTIVE)&&(v<V_ACTIVE).
REQ-016 oADDR SHALL be 0 at h=0,v=0, increment by 1 on each active pixel, and hold during blanking; no divider or multiplier is used for addressing.
REQ-017 Key index SHALL come from an incremental column counter: reset to 0 at h=0, increment index every KEY_W pixels; pixels with index>=NUM_KEYS are non-key.
REQ-018 iKEYS SHALL pass through a 2-flop synchroniser before use.
REQ-019 Per key, an 8-bit level L[k] SHALL update only on the frame-update pulse (h=0, v=V_ACTIVE): synchronised key held -> L=8'hFF; otherwise L=max(L-FADE_STEP,0), saturating at 0 without wrap.
REQ-020 L[k] SHALL remain constant across active video; a press or release mid-frame takes effect from the next frame.
REQ-021 Key colour for index k SHALL be red=255-min(32k,255), green=0, blue=min(32k,255).
REQ-022 Each output channel on an active key pixel SHALL be (kc*L + bg*(255-L))>>8, computed at 16 bits, where kc is the key colour and bg is the iBGR channel; with L=0 the output is bg unchanged.
REQ-023 Non-key active pixels SHALL output iBGR unchanged; blanked pixels SHALL output 0 on all channels.
REQ-024 The pipeline is 2 cycles: counters (stage 0), ROM read/iBGR plus key index and L (stage 1), registered colour (stage 2); oHS, oVS and oBLANK_n SHALL be delayed 2 cycles so they align with the colour outputs.
REQ-025 Simultaneous frame-update pulse and frame wrap cannot occur; when a press lands on the update cycle, the synchronised value at that edge is used.

Reset
REQ-026 While iRST=1 (asynchronous): h, v, oADDR, column counters and all L[k] SHALL be 0; oHS=1, oVS=1, oBLANK_n=0, and colour outputs 0.
REQ-027 After iRST deasserts mid-frame, the block SHALL restart at h=0,v=0 and emit its first oBLANK_n=1 exactly 2 cycles after the first clock.

Verification
REQ-028 Free-run with defaults -> oHS period 800 clocks with 96 low; oVS period 525 lines with 2 low; 307200 oBLANK_n-high cycles per frame; oADDR reaches 307199.
REQ-029 iKEYS=0, iBGR constant 24'h123456 -> every active pixel outputs b=12, g=34, r=56; blanked pixels output 0.
REQ-030 iKEYS[0]=1 held over a frame update, iBGR=0 -> the next frame's pixels x<91 show r=254, g=0, b=0; x>=91 show 0.
REQ-031 Release key 0 after L=FF -> successive frame L values DF, BF, 9F, 7F, 5F, 3F, 1F, 00, then held at 00 with no wrap.
REQ-032 NUM_KEYS=3 -> pixels with x>=273 pass iBGR even when iKEYS=3'b111.
REQ-033 Assert iRST mid-line with keys held -> outputs reach their reset values immediately without a clock; all L values restart at 0.
